lbus_regfile: RTL and testbench

Parametrised local-bus register file for the SPI-to-register path. Accepts level-type read/write enables, address and write data from the SPI clock domain. Synchronises the enables into `clk` and performs exactly one access per enable assertion. Provides a read/write register bank, a read-only status bank, per-register write strobes, registered read data with a valid flag, and a saturating illegal-access counter.

---
 rtl/lbus_regfile.sv | 80 ++++++++
 tb/tb_lbus_regfile.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lbus_regfile.sv
// lbus_regfile: SPI-to-register local bus, enables synchronised into clk, R/W + RO banks
// One access per enable rising edge; saturating illegal-access counter.
module lbus_regfile #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 24,
  parameter int NUM_REGS = 16,
  parameter int RO_BASE  = 12
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 rd_en_sclk,
  input  logic                                 wr_en_sclk,
  input  logic [ADDR_W-1:0]                    address_sclk,
  input  logic [DATA_W-1:0]                    wdata_sclk,
  input  logic [(NUM_REGS-RO_BASE)*DATA_W-1:0] status_i,
  input  logic                                 err_clr,
  output logic [RO_BASE*DATA_W-1:0]            regs_o,
  output logic [RO_BASE-1:0]                   wr_pulse,
  output logic [DATA_W-1:0]                    rdata,
  output logic                                 rdata_valid,
  output logic [7:0]                           err_cnt
);
  localparam logic [ADDR_W:0] RW_LIM  = RO_BASE;
  localparam logic [ADDR_W:0] REG_LIM = NUM_REGS;
  logic [2:0] rd_ff, wr_ff;
  logic rd_evt, wr_evt, in_rw, in_range;
  logic [RO_BASE-1:0] wr_hit;
  logic [DATA_W-1:0] rd_val;
  logic [1:0] inc;
  logic [8:0] sum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ff <= '0;
      wr_ff <= '0;
    end else begin
      rd_ff <= {rd_ff[1:0], rd_en_sclk};
      wr_ff <= {wr_ff[1:0], wr_en_sclk};
    end
  assign rd_evt   = rd_ff[1] & ~rd_ff[2];
  assign wr_evt   = wr_ff[1] & ~wr_ff[2];
  assign in_rw    = {1'b0, address_sclk} < RW_LIM;
  assign in_range = {1'b0, address_sclk} < REG_LIM;
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < RO_BASE; i++) wr_hit[i] = address_sclk == ADDR_W'(i);
  end
  // Full-width index compare, so out-of-range addresses never alias onto a register
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < RO_BASE; i++)
      if (address_sclk == ADDR_W'(i)) rd_val = regs_o[i*DATA_W +: DATA_W];
    for (int k = 0; k < NUM_REGS - RO_BASE; k++)
      if (address_sclk == ADDR_W'(RO_BASE + k)) rd_val = status_i[k*DATA_W +: DATA_W];
  end
  assign inc = 2'(wr_evt & ~in_rw) + 2'(rd_evt & ~in_range);
  assign sum = {1'b0, err_cnt} + {7'b0, inc};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regs_o   <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= wr_evt ? wr_hit : '0;
      for (int i = 0; i < RO_BASE; i++)
        if (wr_evt && wr_hit[i]) regs_o[i*DATA_W +: DATA_W] <= wdata_sclk;
    end
  // Read samples rd_val before the same-edge write lands, giving pre-write data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else if (rd_evt) begin
      rdata       <= in_range ? rd_val : '0;
      rdata_valid <= 1'b1;
    end else if (!rd_ff[1]) begin
      rdata_valid <= 1'b0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_cnt <= '0;
    else err_cnt <= err_clr ? 8'd0 : sum[8] ? 8'hFF : sum[7:0];
endmodule

// File: tb/tb_lbus_regfile.sv
// tb_lbus_regfile: directed stimulus, event-level reference model checked every cycle
module tb_lbus_regfile;
  logic clk = 0, rst_n = 0, rd_en = 0, wr_en = 0, err_clr = 0;
  logic [23:0] addr = 0;
  logic [7:0] wdata = 0;
  logic [31:0] status = 0;
  logic [95:0] regs_o;
  logic [11:0] wr_pulse;
  logic [7:0] rdata, err_cnt;
  logic rdata_valid;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  lbus_regfile dut (
    .clk(clk), .rst_n(rst_n), .rd_en_sclk(rd_en), .wr_en_sclk(wr_en),
    .address_sclk(addr), .wdata_sclk(wdata), .status_i(status), .err_clr(err_clr),
    .regs_o(regs_o), .wr_pulse(wr_pulse), .rdata(rdata), .rdata_valid(rdata_valid),
    .err_cnt(err_cnt)
  );
  logic [7:0] reg_m[12] = '{default: 8'h00};
  logic [7:0] rdata_m = 0;
  logic valid_m = 0;
  logic [11:0] pulse_m = 0;
  int err_m = 0, rd_run = 0, wr_run = 0, rd_low = 0, inc = 0, a = 0;
  function automatic logic [95:0] regs_pack();
    logic [95:0] r;
    for (int i = 0; i < 12; i++) r[i*8 +: 8] = reg_m[i];
    return r;
  endfunction
  task automatic check(input string n, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, got, exp, $time);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic do_wr(input logic [23:0] ad, input logic [7:0] d);
    addr = ad;
    wdata = d;
    cyc(1);
    wr_en = 1;
    cyc(3);
    wr_en = 0;
    cyc(3);
  endtask
  task automatic do_rd(input logic [23:0] ad);
    addr = ad;
    cyc(1);
    rd_en = 1;
    cyc(3);
    rd_en = 0;
    cyc(3);
  endtask
  // Model: an access commits on the 3rd consecutive clk sample of its enable being high
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      foreach (reg_m[i]) reg_m[i] = 0;
      rdata_m = 0; valid_m = 0; pulse_m = 0; err_m = 0;
      rd_run = 0; wr_run = 0; rd_low = 0;
    end else begin
      rd_run = rd_en ? rd_run + 1 : 0;
      wr_run = wr_en ? wr_run + 1 : 0;
      rd_low = rd_en ? 0 : rd_low + 1;
      a = int'(addr);
      pulse_m = 0;
      inc = 0;
      if (rd_run == 3) begin
        valid_m = 1;
        if (a < 12) rdata_m = reg_m[a];
        else if (a < 16) rdata_m = status[(a-12)*8 +: 8];
        else begin
          rdata_m = 0;
          inc++;
        end
      end else if (rd_low == 3) valid_m = 0;
      if (wr_run == 3) begin
        if (a < 12) begin
          reg_m[a] = wdata;
          pulse_m[a] = 1'b1;
        end else inc++;
      end
      err_m = err_clr ? 0 : (err_m + inc > 255 ? 255 : err_m + inc);
    end
  end
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("cyc_regs", regs_o, regs_pack());
      check("cyc_pulse", wr_pulse, pulse_m);
      check("cyc_rdata", rdata, rdata_m);
      check("cyc_valid", rdata_valid, valid_m);
      check("cyc_err", err_cnt, err_m);
    end
  end
  initial begin
    int n;
    cyc(2);
    check("rst_regs", regs_o, 0);
    check("rst_err", err_cnt, 0);
    check("rst_valid", rdata_valid, 0);
    rst_n = 1;
    cyc(2);
    addr = 3; wdata = 8'hA5;
    cyc(1);
    wr_en = 1;
    cyc(3);
    check("rt_reg3", regs_o[31:24], 8'hA5);
    check("rt_pulse", wr_pulse, 12'h008);
    cyc(1);
    check("rt_pulse_off", wr_pulse, 0);
    wr_en = 0;
    cyc(4);
    rd_en = 1;
    cyc(3);
    check("rt_rdata", rdata, 8'hA5);
    check("rt_valid", rdata_valid, 1);
    rd_en = 0;
    cyc(2);
    check("rt_valid_hold", rdata_valid, 1);
    cyc(1);
    check("rt_valid_drop", rdata_valid, 0);
    check("rt_rdata_hold", rdata, 8'hA5);
    addr = 0; wdata = 8'h3C;
    cyc(1);
    wr_en = 1;
    n = 0;
    repeat (50) begin
      cyc(1);
      n += int'(wr_pulse[0]);
    end
    wr_en = 0;
    cyc(4);
    check("long_pulses", n, 1);
    check("long_err", err_cnt, 0);
    do_wr(24'd13, 8'h77);
    do_wr(24'h000100, 8'h77);
    do_rd(24'h000010);
    check("ill_err", err_cnt, 3);
    check("ill_rdata", rdata, 0);
    check("ill_regs", regs_o, 96'h0000_0000_0000_0000_A500_003C);
    status = 32'h4B_E7_9D_5C;
    do_rd(24'd12);
    check("ro_rd12", rdata, 8'h5C);
    do_rd(24'd15);
    check("ro_rd15", rdata, 8'h4B);
    do_wr(24'd2, 8'h11);
    addr = 2; wdata = 8'h22;
    cyc(1);
    rd_en = 1; wr_en = 1;
    cyc(3);
    check("sim_rdata", rdata, 8'h11);
    check("sim_reg2", regs_o[23:16], 8'h22);
    rd_en = 0; wr_en = 0;
    cyc(4);
    repeat (300) do_wr(24'd13, 8'h77);
    check("sat_err", err_cnt, 255);
    wr_en = 1;
    cyc(2);
    err_clr = 1;
    cyc(1);
    err_clr = 0;
    check("clr_wins", err_cnt, 0);
    wr_en = 0;
    cyc(4);
    addr = 5; wdata = 8'h6E;
    cyc(1);
    wr_en = 1;
    cyc(3);
    check("mid_reg5", regs_o[47:40], 8'h6E);
    rst_n = 0;
    #1;
    check("mid_rst_regs", regs_o, 0);
    check("mid_rst_pulse", wr_pulse, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_valid", rdata_valid, 0);
    check("mid_rst_err", err_cnt, 0);
    cyc(2);
    rst_n = 1;
    n = 0;
    repeat (6) begin
      cyc(1);
      n += int'(wr_pulse[5]);
    end
    check("rel_pulses", n, 1);
    check("rel_reg5", regs_o[47:40], 8'h6E);
    wr_en = 0;
    cyc(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
